// File: rtl/ula_pkg.sv
// Shared definitions for the nibble-serial 74181 ALU: slice width, the two
// arithmetic selects that carry signed-overflow meaning, and the FSM states.
package ula_pkg;

  localparam int unsigned SLICE_W = 4;

  localparam logic [3:0] S_ADD = 4'b1001;  // m=0: A plus B
  localparam logic [3:0] S_SUB = 4'b0110;  // m=0: A minus B minus 1 (plus carry)

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ula_74181.sv
// One 4-bit 74181-style ALU slice, active-high data and active-high carry.
// Ports:
//   a, b    : 4-bit operands
//   s, m    : function select, 1 = logic mode / 0 = arithmetic mode
//   c_in    : carry into bit 0 (1 = carry)
//   f       : 4-bit result
//   c_out   : carry out of bit 3 (computed in both modes, as on the part)
//   a_eq_b  : all result bits set
//   p, g    : group propagate / generate for lookahead chaining
module ula_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       c_in,
  output logic [3:0] f,
  output logic       c_out,
  output logic       a_eq_b,
  output logic       p,
  output logic       g
);

  // t1/t2 are the two per-bit addends; t2 is always a subset of t1, so t1 acts
  // as the bit propagate and t2 as the bit generate.
  logic [3:0] t1;
  logic [3:0] t2;
  logic [3:0] cy;
  logic       c1;
  logic       c2;
  logic       c3;

  always_comb begin
    t1 = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    t2 = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});

    c1 = t2[0] | (t1[0] & c_in);
    c2 = t2[1] | (t1[1] & c1);
    c3 = t2[2] | (t1[2] & c2);
    cy = {c3, c2, c1, c_in};

    p = &t1;
    g = t2[3] | (t1[3] & t2[2]) | (t1[3] & t1[2] & t2[1]) |
        (t1[3] & t1[2] & t1[1] & t2[0]);
    c_out = g | (p & c_in);

    // Logic mode inverts the half sum and ignores the carry chain.
    f      = m ? ~(t1 ^ t2) : (t1 ^ t2 ^ cy);
    a_eq_b = &f;
  end

endmodule

// File: rtl/ula_nibble_serial.sv
// Multi-cycle WIDTH-bit 74181 ALU: one ula_74181 slice is iterated over the
// operand nibbles LSB first, with the carry rippled through a register.
// Optional feature macro: ULA_OVERFLOW_EN (signed overflow for ADD/SUB);
// when undefined, overflow is tied to 0.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : request handshake for a, b, s, m, c_in
//   out_valid / out_ready: result handshake for f, c_out, a_eq_b, p, g, overflow
module ula_nibble_serial
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             p,
  output logic             g,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE_W;
  localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic             p_q;
  logic             g_q;
  logic             eq_q;

  logic             accept_c;
  logic             step_c;
  logic             last_c;

  logic [SLICE_W-1:0] sl_f;
  logic               sl_co;
  logic               sl_eq;
  logic               sl_p;
  logic               sl_g;

  // Operands shift right each step, so the slice always sees the low nibble.
  ula_74181 u_slice (
    .a      (a_q[SLICE_W-1:0]),
    .b      (b_q[SLICE_W-1:0]),
    .s      (s_q),
    .m      (m_q),
    .c_in   (carry_q),
    .f      (sl_f),
    .c_out  (sl_co),
    .a_eq_b (sl_eq),
    .p      (sl_p),
    .g      (sl_g)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = (idx_q == IDX_LAST);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (last_c) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

  // Operand capture, per-nibble accumulation and result assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      carry_q <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      eq_q    <= 1'b0;
    end else if (accept_c) begin
      idx_q   <= '0;
      a_q     <= a;
      b_q     <= b;
      s_q     <= s;
      m_q     <= m;
      carry_q <= c_in;
      p_q     <= 1'b1;
      g_q     <= 1'b0;
      eq_q    <= 1'b1;
    end else if (step_c) begin
      a_q     <= a_q >> SLICE_W;
      b_q     <= b_q >> SLICE_W;
      // New nibble enters at the top; after NSLICE steps nibble 0 is at the bottom.
      f_q     <= (f_q >> SLICE_W) | (WIDTH'(sl_f) << (WIDTH - SLICE_W));
      carry_q <= sl_co;
      eq_q    <= eq_q & sl_eq;
      p_q     <= p_q & sl_p;
      g_q     <= sl_g | (sl_p & g_q);
      if (!last_c) idx_q <= idx_q + IDX_W'(1);
    end
  end

  assign f      = f_q;
  assign c_out  = carry_q;
  assign a_eq_b = eq_q;
  assign p      = p_q;
  assign g      = g_q;

`ifdef ULA_OVERFLOW_EN
  logic a_msb_q;
  logic b_msb_q;
  logic ovf_q;
  logic ovf_c;

  // Uses the last slice's top bit, which becomes f[MSB] on the final step.
  always_comb begin
    ovf_c = 1'b0;
    if (!m_q) begin
      if (s_q == S_ADD) ovf_c = (a_msb_q == b_msb_q) && (sl_f[SLICE_W-1] != a_msb_q);
      if (s_q == S_SUB) ovf_c = (a_msb_q != b_msb_q) && (sl_f[SLICE_W-1] == b_msb_q);
    end
  end

  // Operand signs kept from the accept cycle, since the operands are shifted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept_c) begin
      a_msb_q <= a[WIDTH-1];
      b_msb_q <= b[WIDTH-1];
      ovf_q   <= 1'b0;
    end else if (step_c && last_c) begin
      ovf_q   <= ovf_c;
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
